// File: rtl/mdio_mgmt_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_mgmt_arbiter
//
// Shares a single MDIO frame engine among NUM_REQ management clients (link
// pollers, PHY init sequencers, CSR bridges, ...). Clients are served
// round-robin, one transaction at a time. Each response goes back to the
// client that issued the command. A minimum idle gap separates the
// completion of one frame from the issue of the next.
//
// Transaction flow: IDLE -> ISSUE -> WAIT -> RESP -> GAP -> IDLE
//
// Optional feature macro: MDIO_TIMEOUT_EN
//   When it is defined, a 16-bit watchdog runs in ISSUE and WAIT. On
//   expiry it completes the transaction with rsp_err=1 and
//   rsp_rdata=16'hFFFF. When it is not defined, there is no watchdog and
//   rsp_err is tied to 0.
//
// Parameters
//   NUM_REQ     number of clients (2..8)
//   GAP_CYCLES  minimum idle clk cycles after eng_done (1..255)
//   TO_CYCLES   watchdog limit in clk cycles (timeout build only)
//
// Ports
//   clk, reset        system clock; asynchronous active-low reset
//   req_valid/ready   per-client request handshake (ready is one-hot or 0)
//   req_write         per-client direction, 1 = write
//   req_phy/req_reg   per-client 5-bit addresses, client i at [5i+4:5i]
//   req_wdata         per-client write data, client i at [16i+15:16i]
//   rsp_valid         one-cycle completion pulse to the issuing client
//   rsp_rdata         read data, held until the next response
//   rsp_err           qualifies rsp_valid, 1 = watchdog timeout
//   eng_cmd_valid/ready  command handshake to the frame engine
//   eng_write/phy/reg/wdata  command fields, stable while eng_cmd_valid=1
//   eng_done/eng_rdata   frame-complete pulse and its read data
//   busy              1 in any state other than IDLE
//   grant_id          index of the current or last granted client
// -----------------------------------------------------------------------------
module mdio_mgmt_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int TO_CYCLES  = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [5*NUM_REQ-1:0]         req_phy,
  input  logic [5*NUM_REQ-1:0]         req_reg,
  input  logic [16*NUM_REQ-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [15:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic                         eng_cmd_valid,
  input  logic                         eng_cmd_ready,
  output logic                         eng_write,
  output logic [4:0]                   eng_phy,
  output logic [4:0]                   eng_reg,
  output logic [15:0]                  eng_wdata,
  input  logic                         eng_done,
  input  logic [15:0]                  eng_rdata,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  // Reject out-of-range configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mdio_mgmt_arbiter: NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("mdio_mgmt_arbiter: GAP_CYCLES must be 1..255");
  end
  if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_to
    $error("mdio_mgmt_arbiter: TO_CYCLES must be 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IDW-1:0]   grant_id_q,  grant_id_d;
  logic             eng_write_q, eng_write_d;
  logic [4:0]       eng_phy_q,   eng_phy_d;
  logic [4:0]       eng_reg_q,   eng_reg_d;
  logic [15:0]      eng_wdata_q, eng_wdata_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic [7:0]       gap_cnt_q,   gap_cnt_d;
`ifdef MDIO_TIMEOUT_EN
  logic [15:0]      wd_cnt_q,    wd_cnt_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             wd_expired;
`endif

  // Per-client request fields unpacked from the flat buses.
  logic [4:0]  phy_arr   [NUM_REQ];
  logic [4:0]  reg_arr   [NUM_REQ];
  logic [15:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign phy_arr[g]   = req_phy[5*g +: 5];
    assign reg_arr[g]   = req_reg[5*g +: 5];
    assign wdata_arr[g] = req_wdata[16*g +: 16];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first requester at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic           pick_any;
  logic [IDW-1:0] pick_idx;

  always_comb begin : rr_pick
    logic [IDW:0] sum;
    // NOTE: every variable written in a combinational block gets a default
    // first. Without it, a path that leaves the variable unassigned infers a
    // latch.
    sum      = '0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      if (!pick_any && req_valid[IDW'(sum)]) begin
        pick_any = 1'b1;
        pick_idx = IDW'(sum);
      end
    end
  end

  // req_ready is combinational, so the accept happens in the same cycle as
  // the grant decision.
  always_comb begin : ready_gen
    req_ready = '0;
    if (state_q == S_IDLE && pick_any) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  always_comb begin : rsp_gen
    rsp_valid = '0;
    if (state_q == S_RESP) begin
      rsp_valid[grant_id_q] = 1'b1;
    end
  end

`ifdef MDIO_TIMEOUT_EN
  assign wd_expired = (wd_cnt_q == 16'(TO_CYCLES));
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    eng_write_d = eng_write_q;
    eng_phy_d   = eng_phy_q;
    eng_reg_d   = eng_reg_q;
    eng_wdata_d = eng_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef MDIO_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_id_d  = pick_idx;
          eng_write_d = req_write[pick_idx];
          eng_phy_d   = phy_arr[pick_idx];
          eng_reg_d   = reg_arr[pick_idx];
          eng_wdata_d = wdata_arr[pick_idx];
          state_d     = S_ISSUE;
`ifdef MDIO_TIMEOUT_EN
          wd_cnt_d    = '0;
          rsp_err_d   = 1'b0;
`endif
        end
      end

      S_ISSUE: begin
        // An accept that lands on the expiry cycle still wins: the engine
        // now owns the frame and its eng_done will follow.
        if (eng_cmd_ready) begin
          state_d = S_WAIT;
`ifdef MDIO_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 16'd1;
        end else if (wd_expired) begin
          rsp_rdata_d = 16'hFFFF;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
`endif
        end
      end

      S_WAIT: begin
        if (eng_done) begin
          // Writes return no data; report zero rather than bus noise.
          rsp_rdata_d = eng_write_q ? 16'h0000 : eng_rdata;
          state_d     = S_RESP;
`ifdef MDIO_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wd_expired) begin
          rsp_rdata_d = 16'hFFFF;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
`endif
        end
      end

      S_RESP: begin
        rr_ptr_d  = (grant_id_q == IDW'(NUM_REQ-1)) ? '0 : grant_id_q + IDW'(1);
        gap_cnt_d = 8'(GAP_CYCLES-1);
        state_d   = S_GAP;
      end

      S_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the value from before the clock edge regardless of
  // statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      eng_write_q <= 1'b0;
      eng_phy_q   <= '0;
      eng_reg_q   <= '0;
      eng_wdata_q <= '0;
      rsp_rdata_q <= '0;
      gap_cnt_q   <= '0;
`ifdef MDIO_TIMEOUT_EN
      wd_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      eng_write_q <= eng_write_d;
      eng_phy_q   <= eng_phy_d;
      eng_reg_q   <= eng_reg_d;
      eng_wdata_q <= eng_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef MDIO_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign eng_cmd_valid = (state_q == S_ISSUE);
  assign eng_write     = eng_write_q;
  assign eng_phy       = eng_phy_q;
  assign eng_reg       = eng_reg_q;
  assign eng_wdata     = eng_wdata_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_id_q;

`ifdef MDIO_TIMEOUT_EN
  assign rsp_err = rsp_err_q & (state_q == S_RESP);
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdio_mgmt_arbiter
//
// Self-checking bench for mdio_mgmt_arbiter (NUM_REQ=4, GAP_CYCLES=8,
// TO_CYCLES=64). A table of single-transaction vectors covers arbitration,
// field routing, backpressure and read/write data. Hand-written sequences
// cover reset, abort on mid-transaction reset, round-robin fairness with
// gap spacing, and the watchdog when MDIO_TIMEOUT_EN is defined.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdio_mgmt_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int TO_CYCLES  = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_REQ-1:0]  req_valid;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  req_write;
  logic [5*NUM_REQ-1:0]  req_phy;
  logic [5*NUM_REQ-1:0]  req_reg;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]  rsp_valid;
  logic [15:0]         rsp_rdata;
  logic                rsp_err;
  logic                eng_cmd_valid;
  logic                eng_cmd_ready;
  logic                eng_write;
  logic [4:0]          eng_phy;
  logic [4:0]          eng_reg;
  logic [15:0]         eng_wdata;
  logic                eng_done;
  logic [15:0]         eng_rdata;
  logic                busy;
  logic [1:0]          grant_id;

  always #5 clk = ~clk;

  mdio_mgmt_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .TO_CYCLES  (TO_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_phy       (req_phy),
    .req_reg       (req_reg),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_cmd_ready (eng_cmd_ready),
    .eng_write     (eng_write),
    .eng_phy       (eng_phy),
    .eng_reg       (eng_reg),
    .eng_wdata     (eng_wdata),
    .eng_done      (eng_done),
    .eng_rdata     (eng_rdata),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] eng_rdata;
    int          ready_delay;
    int          exp_grant;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic set_client(input int c, input logic wr, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] wd);
    req_write[c]          = wr;
    req_phy[5*c +: 5]     = phy;
    req_reg[5*c +: 5]     = rg;
    req_wdata[16*c +: 16] = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},     32'(req_ready),     32'd0);
    check({tag, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    check({tag, "_rsp_rdata"},     32'(rsp_rdata),     32'd0);
    check({tag, "_rsp_err"},       32'(rsp_err),       32'd0);
    check({tag, "_eng_cmd_valid"}, 32'(eng_cmd_valid), 32'd0);
    check({tag, "_eng_fields"},
          32'({eng_write, eng_phy, eng_reg, eng_wdata}), 32'd0);
    check({tag, "_busy"},          32'(busy),          32'd0);
    check({tag, "_grant_id"},      32'(grant_id),      32'd0);
  endtask

  // Wait (bounded) until req_ready shows a grant. Returns at negedge+1ns.
  task automatic wait_grant(input string tag, output bit got);
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      #1;
      if (req_ready != '0) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_grant_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    bit stable;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v.mask[i]) begin
        if (i == v.exp_grant)
          set_client(i, v.write, v.phy, v.regad, v.wdata);
        else
          set_client(i, 1'b0, 5'(16 + i), 5'(20 + i), 16'(16'hC000 + i));
      end
    end
    req_valid = v.mask;
    wait_grant(t, got);
    if (!got) begin
      req_valid = '0;
      return;
    end
    check({t, "_req_ready"}, 32'(req_ready), 32'(4'd1 << v.exp_grant));
    @(negedge clk);
    req_valid = '0;
    #1;
    check({t, "_issue_valid"}, 32'(eng_cmd_valid), 32'd1);
    check({t, "_grant_id"},    32'(grant_id),      32'(v.exp_grant));
    check({t, "_busy"},        32'(busy),          32'd1);
    check({t, "_eng_fields"},  32'({eng_write, eng_phy, eng_reg}),
          32'({v.write, v.phy, v.regad}));
    check({t, "_eng_wdata"},   32'(eng_wdata),     32'(v.wdata));
    stable = 1'b1;
    for (int k = 0; k < v.ready_delay; k++) begin
      @(negedge clk);
      #1;
      if (eng_cmd_valid !== 1'b1 || eng_write !== v.write || eng_phy !== v.phy ||
          eng_reg !== v.regad || eng_wdata !== v.wdata)
        stable = 1'b0;
    end
    check({t, "_cmd_stable"}, 32'(stable), 32'd1);
    eng_cmd_ready = 1'b1;
    @(negedge clk);
    eng_cmd_ready = 1'b0;
    #1;
    check({t, "_valid_dropped"}, 32'(eng_cmd_valid), 32'd0);
    repeat (3) @(negedge clk);
    eng_done  = 1'b1;
    eng_rdata = v.eng_rdata;
    @(negedge clk);
    eng_done  = 1'b0;
    eng_rdata = 16'hDEAD;
    #1;
    check({t, "_rsp_valid"}, 32'(rsp_valid), 32'(4'd1 << v.exp_grant));
    check({t, "_rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    check({t, "_rsp_err"},   32'(rsp_err),   32'd0);
    @(negedge clk);
    #1;
    check({t, "_rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    check({t, "_rdata_held"},    32'(rsp_rdata), 32'(v.exp_rdata));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit got;
    bit seen;
    bit stray;
    int n;

    // Expected grants assume rr_ptr walks grant+1 after every response.
    vecs[0] = '{4'b0100, 1'b0, 5'h01, 5'h02, 16'h0000, 16'h796D,  0, 2, 16'h796D};
    vecs[1] = '{4'b0010, 1'b1, 5'h03, 5'h04, 16'h1200, 16'hBEEF, 20, 1, 16'h0000};
    vecs[2] = '{4'b1111, 1'b0, 5'h1F, 5'h1F, 16'h0000, 16'hA5A5,  2, 2, 16'hA5A5};
    vecs[3] = '{4'b0011, 1'b0, 5'h0A, 5'h15, 16'h0000, 16'h0001,  1, 0, 16'h0001};
    vecs[4] = '{4'b1001, 1'b1, 5'h11, 5'h0E, 16'hFFFF, 16'h1234,  3, 3, 16'h0000};
    vecs[5] = '{4'b1010, 1'b0, 5'h00, 5'h00, 16'h0000, 16'h8000,  0, 1, 16'h8000};
    vecs[6] = '{4'b0001, 1'b0, 5'h07, 5'h19, 16'h0000, 16'hC3C3,  0, 0, 16'hC3C3};

    reset         = 1'b0;
    req_valid     = '0;
    req_write     = '0;
    req_phy       = '0;
    req_reg       = '0;
    req_wdata     = '0;
    eng_cmd_ready = 1'b0;
    eng_done      = 1'b0;
    eng_rdata     = 16'h0000;

    // Reset, then idle.
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("in_reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("after_reset");

    // Table-driven transactions.
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a transaction: abort, no response.
    @(negedge clk);
    set_client(0, 1'b0, 5'h05, 5'h06, 16'h0000);
    req_valid = 4'b0001;
    wait_grant("abort", got);
    @(negedge clk);
    req_valid     = '0;
    eng_cmd_ready = 1'b1;
    @(negedge clk);
    eng_cmd_ready = 1'b0;
    #1;
    check("abort_in_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("abort_reset");
    @(negedge clk);
    reset    = 1'b1;
    eng_done = 1'b1;   // late done from the aborted frame, arrives in IDLE
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("abort_no_rsp",  32'(rsp_valid), 32'd0);
    check("abort_idle",    32'(busy),      32'd0);

    // Round-robin with all clients requesting continuously.
    for (int c = 0; c < NUM_REQ; c++) set_client(c, 1'b0, 5'(c), 5'(c + 8), 16'h0000);
    @(negedge clk);
    req_valid = '1;
    stray     = 1'b0;
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 200) begin
        @(negedge clk);
        #1;
        n++;
        if (g > 0) begin
          if (n == 1) begin
            eng_done = 1'b0;
            check($sformatf("rr%0d_rsp_valid", g - 1), 32'(rsp_valid),
                  32'(4'd1 << ((g - 1) % 4)));
            check($sformatf("rr%0d_rsp_rdata", g - 1), 32'(rsp_rdata),
                  32'(16'h1000 + 16'(g - 1)));
          end else if (rsp_valid != '0) begin
            stray = 1'b1;
          end
          // Stray done while the arbiter sits in GAP must be ignored.
          if (n == 4) eng_done = 1'b1;
          if (n == 5) eng_done = 1'b0;
        end
        if (eng_cmd_valid) seen = 1'b1;
      end
      check($sformatf("rr%0d_issue_seen", g), 32'(seen), 32'd1);
      check($sformatf("rr%0d_grant_id", g), 32'(grant_id), 32'(g % 4));
      check($sformatf("rr%0d_eng_phy", g),  32'(eng_phy),  32'(g % 4));
      if (g > 0) begin
        // n-1 = cycles from the eng_done sampling edge to eng_cmd_valid.
        check($sformatf("rr%0d_gap_min", g), 32'(n - 1 >= GAP_CYCLES + 2), 32'd1);
        check($sformatf("rr%0d_gap_max", g), 32'(n - 1 <= GAP_CYCLES + 3), 32'd1);
      end
      if (g == 4) req_valid = '0;
      eng_cmd_ready = 1'b1;
      @(negedge clk);
      eng_cmd_ready = 1'b0;
      @(negedge clk);
      eng_done  = 1'b1;
      eng_rdata = 16'h1000 + 16'(g);
    end
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("rr4_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rr4_rsp_rdata", 32'(rsp_rdata), 32'h1004);
    check("rr_no_stray_rsp", 32'(stray), 32'd0);

`ifdef MDIO_TIMEOUT_EN
    // Watchdog: the engine never accepts or completes.
    @(negedge clk);
    set_client(3, 1'b0, 5'h02, 5'h03, 16'h0000);
    req_valid = 4'b1000;
    wait_grant("to", got);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("to_rsp_seen",  32'(seen), 32'd1);
    check("to_latency",   32'(n >= 64 && n <= 66), 32'd1);
    check("to_rsp_valid", 32'(rsp_valid), 32'h8);
    check("to_rsp_err",   32'(rsp_err),   32'd1);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'hFFFF);
    check("to_cmd_drop",  32'(eng_cmd_valid), 32'd0);
    @(negedge clk);
    eng_done  = 1'b1;
    eng_rdata = 16'h5555;
    @(negedge clk);
    eng_done  = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid != '0) stray = 1'b1;
      @(negedge clk);
    end
    check("to_late_done_ignored", 32'(stray), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
